// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, prefix FSM states and BCD digit width shared by the PS/2 command decoder
package ps2_pkg;
   localparam int BCD_W = 4;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_DEL   = 8'h71;
   localparam logic [79:0] SC_MAIN = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
   localparam logic [79:0] SC_KPAD = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};
   localparam logic [63:0] SC_FKEY = {8'h0A, 8'h83, 8'h0B, 8'h03, 8'h0C, 8'h04, 8'h06, 8'h05};
   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
   function automatic logic [4:0] digit_of(input logic [7:0] c);
      digit_of = '0;
      for (int i = 0; i < 10; i++)
         if (c == SC_MAIN[8*i +: 8] || c == SC_KPAD[8*i +: 8]) digit_of = {1'b1, 4'(i)};
   endfunction
   function automatic logic [7:0] fkey_mask(input logic [7:0] c);
      fkey_mask = '0;
      for (int i = 0; i < 8; i++)
         if (c == SC_FKEY[8*i +: 8]) fkey_mask[i] = 1'b1;
   endfunction
endpackage

// File: rtl/ps2_bcd_entry.sv
// ps2_bcd_entry: DIGITS-wide pending BCD shift register with digit count
//   clk, rst           clock, sync active-high reset
//   push/digit         shift left, insert digit at LSD (ignored when full)
//   pop                shift right, drop LSD (ignored when empty)
//   clr, commit        clear pending and count
//   pending, full, empty
module ps2_bcd_entry
   import ps2_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      clr,
   input  logic                      commit,
   input  logic [BCD_W-1:0]          digit,
   output logic [BCD_W*DIGITS-1:0]   pending,
   output logic                      full,
   output logic                      empty
);
   localparam int W  = BCD_W * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   logic [W-1:0]  pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   assign full    = cnt_q == CW'(DIGITS);
   assign empty   = cnt_q == '0;
   assign pending = pend_q;
   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (clr || commit) begin
         pend_d = '0;
         cnt_d  = '0;
      end else if (push && !full) begin
         pend_d = (pend_q << BCD_W) | W'(digit);
         cnt_d  = cnt_q + 1'b1;
      end else if (pop && !empty) begin
         pend_d = pend_q >> BCD_W;
         cnt_d  = cnt_q - 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/ps2_key_command_decoder.sv
// ps2_key_command_decoder: PS/2 scan-code prefix filter and key command interpreter
//   CLK, reset             clock, sync active-high reset
//   rx_tick, din           received byte strobe and byte
//   value_bcd, value_valid committed BCD entry and its update pulse
//   flags                  toggled alarm flags
//   fsm_reset              Esc pulse
//   entry_active           digits pending
//   err                    rejected key pulse
//   Macro PS2_EXT_KEYS_EN enables E0-prefixed key tracking.
module ps2_key_command_decoder
   import ps2_pkg::*;
#(
   parameter int DIGITS    = 2,
   parameter int NUM_FLAGS = 3,
   parameter int TIMEOUT   = 50000
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      rx_tick,
   input  logic [7:0]                din,
   output logic [BCD_W*DIGITS-1:0]   value_bcd,
   output logic                      value_valid,
   output logic [NUM_FLAGS-1:0]      flags,
   output logic                      fsm_reset,
   output logic                      entry_active,
   output logic                      err
);
`ifdef PS2_EXT_KEYS_EN
   localparam bit EXT_EN = 1'b1;
`else
   localparam bit EXT_EN = 1'b0;
`endif
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t                    state_q, state_d;
   logic [TW-1:0]             tmr_q, tmr_d;
   logic [8:0]                held_q, held_d;
   logic                      held_v_q, held_v_d;
   logic [BCD_W*DIGITS-1:0]   value_q, value_d;
   logic                      value_valid_q, value_valid_d;
   logic [NUM_FLAGS-1:0]      flags_q, flags_d;
   logic                      fsm_reset_q, fsm_reset_d;
   logic                      err_q, err_d;
   logic                      is_make, is_brk, ext_bit;
   logic [8:0]                key;
   logic [4:0]                dig;
   logic                      push, pop, clr, commit, full, empty;
   logic [BCD_W*DIGITS-1:0]   pending;
   ps2_bcd_entry #(.DIGITS(DIGITS)) u_entry (
      .clk     (CLK),
      .rst     (reset),
      .push    (push),
      .pop     (pop),
      .clr     (clr),
      .commit  (commit),
      .digit   (dig[3:0]),
      .pending (pending),
      .full    (full),
      .empty   (empty)
   );
   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      held_d        = held_q;
      held_v_d      = held_v_q;
      value_d       = value_q;
      flags_d       = flags_q;
      value_valid_d = 1'b0;
      fsm_reset_d   = 1'b0;
      err_d         = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      clr           = 1'b0;
      commit        = 1'b0;
      is_make       = 1'b0;
      is_brk        = 1'b0;
      ext_bit       = 1'b0;
      if (rx_tick) begin
         tmr_d   = '0;
         state_d = S_IDLE;
         case (state_q)
            S_IDLE: begin
               if (din == SC_BRK) state_d = S_BRK;
               else if (din == SC_EXT) state_d = EXT_EN ? S_EXT : S_IDLE;
               else is_make = 1'b1;
            end
            S_EXT: begin
               ext_bit = 1'b1;
               if (din == SC_BRK) state_d = S_EXT_BRK;
               else is_make = 1'b1;
            end
            S_BRK: is_brk = 1'b1;
            default: begin
               ext_bit = 1'b1;
               is_brk  = 1'b1;
            end
         endcase
      end else if (state_q != S_IDLE) begin
         tmr_d = tmr_q + 1'b1;
         if (tmr_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      end
      key = {ext_bit, din};
      dig = digit_of(din);
      if (is_brk && held_v_q && held_q == key) held_v_d = 1'b0;
      // a make equal to the held key is a typematic repeat and is dropped
      if (is_make && !(held_v_q && held_q == key)) begin
         held_d   = key;
         held_v_d = 1'b1;
         if (din == SC_ENTER) begin
            err_d         = empty;
            commit        = !empty;
            value_valid_d = !empty;
            value_d       = empty ? value_q : pending;
         end else if (ext_bit) begin
            clr = din == SC_DEL;
         end else if (dig[4]) begin
            err_d = full;
            push  = !full;
         end else if (din == SC_BKSP) begin
            err_d = empty;
            pop   = !empty;
         end else if (din == SC_ESC) begin
            clr         = 1'b1;
            fsm_reset_d = 1'b1;
         end else begin
            flags_d = flags_q ^ NUM_FLAGS'(fkey_mask(din));
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q       <= S_IDLE;
         tmr_q         <= '0;
         held_q        <= '0;
         held_v_q      <= 1'b0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         flags_q       <= '0;
         fsm_reset_q   <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         held_q        <= held_d;
         held_v_q      <= held_v_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         flags_q       <= flags_d;
         fsm_reset_q   <= fsm_reset_d;
         err_q         <= err_d;
      end
   end
   assign value_bcd    = value_q;
   assign value_valid  = value_valid_q;
   assign flags        = flags_q;
   assign fsm_reset    = fsm_reset_q;
   assign entry_active = !empty;
   assign err          = err_q;
endmodule
